// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array and its tile sequencer.
package systolic_array_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        WAIT,
        OUT
    } ctrl_state_t;

endpackage

// File: rtl/systolic_array_ctrl_beat_reg.sv
// Beat register between the operand buffers and the array inputs.
// Read data arrives the cycle after a read request and is presented to the
// array straight away; it is captured into the holding register at the end of
// that cycle so the beat stays stable for as long as the array stalls.
module beat_reg
    import systolic_array_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic            consume,
    input  word_t [N-1:0]   x_rd_data,
    input  word_t [N-1:0]   w_rd_data,
    output word_t [N-1:0]   x_beat,
    output word_t [N-1:0]   w_beat,
    output logic            valid
);

    logic          pending;
    word_t [N-1:0] x_held;
    word_t [N-1:0] w_held;

    // Track in-flight reads, capture arriving data, and keep the beat-present flag.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pending <= 1'b0;
            valid   <= 1'b0;
            x_held  <= '0;
            w_held  <= '0;
        end else begin
            pending <= load;
            if (pending) begin
                x_held <= x_rd_data;
                w_held <= w_rd_data;
            end
            if (load) begin
                valid <= 1'b1;
            end else if (consume) begin
                valid <= 1'b0;
            end
        end
    end

    // Fresh read data bypasses the holding register in its arrival cycle.
    always_comb begin
        x_beat = pending ? x_rd_data : x_held;
        w_beat = pending ? w_rd_data : w_held;
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer: loads 2N operand beats, flushes N-1 zero beats, waits for
// the array to settle, then streams N result rows over valid/ready.
module systolic_array_ctrl
    import systolic_array_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = $clog2(2*N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   go,
    output logic                   busy,
    output logic                   done,
    output logic                   x_rd_en,
    output logic                   w_rd_en,
    output logic [AW-1:0]          x_rd_addr,
    output logic [AW-1:0]          w_rd_addr,
    input  word_t [N-1:0]          x_rd_data,
    input  word_t [N-1:0]          w_rd_data,
    output logic                   arr_start,
    output word_t [N-1:0]          arr_x_in,
    output word_t [N-1:0]          arr_w_in,
    input  logic                   arr_stall,
    output logic [$clog2(N)-1:0]   arr_row_sel,
    input  word_t [N-1:0]          arr_y_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output word_t [N-1:0]          res_data,
    output logic [$clog2(N)-1:0]   res_idx
);

    localparam int unsigned CW = $clog2(2*N + 1);
    localparam int unsigned RW = $clog2(N);
    localparam logic [CW-1:0] BEAT_END   = CW'(2*N);
    localparam logic [CW-1:0] FLUSH_LAST = CW'((N > 1) ? N - 2 : 0);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    ctrl_state_t   state, state_nxt;
    logic [CW-1:0] beat_cnt, beat_nxt;
    logic [RW-1:0] row_cnt, row_nxt;
    logic          rd_en;
    logic          beat_clear;
    logic          beat_valid;
    logic          consume;

    beat_reg #(.N(N)) u_beat_reg (
        .clk       (clk),
        .rst       (rst),
        .clear     (beat_clear),
        .load      (rd_en),
        .consume   (consume),
        .x_rd_data (x_rd_data),
        .w_rd_data (w_rd_data),
        .x_beat    (arr_x_in),
        .w_beat    (arr_w_in),
        .valid     (beat_valid)
    );

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            row_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            row_cnt  <= row_nxt;
        end
    end

    // Next-state, counter updates and all sequencer outputs.
    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat_cnt;
        row_nxt     = row_cnt;
        rd_en       = 1'b0;
        beat_clear  = 1'b0;
        consume     = 1'b0;
        done        = 1'b0;
        arr_start   = 1'b0;
        res_valid   = 1'b0;
        arr_row_sel = '0;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt  = LOAD;
                    beat_nxt   = '0;
                    row_nxt    = '0;
                    beat_clear = 1'b1;
                end
            end
            LOAD: begin
                arr_start = 1'b1;
                consume   = beat_valid && !arr_stall;
                // A stalled, occupied beat register blocks the next read.
                if (beat_cnt < BEAT_END && (!beat_valid || !arr_stall)) begin
                    rd_en    = 1'b1;
                    beat_nxt = beat_cnt + 1'b1;
                end
                // All reads issued and the beat on display is consumed: that was the last one.
                if (beat_cnt == BEAT_END && consume) begin
                    beat_clear = 1'b1;
                    beat_nxt   = '0;
                    state_nxt  = (N > 1) ? FLUSH : WAIT;
                end
            end
            FLUSH: begin
                arr_start = 1'b1;
                if (!arr_stall) begin
                    if (beat_cnt == FLUSH_LAST) begin
                        beat_nxt  = '0;
                        state_nxt = WAIT;
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            WAIT: begin
                arr_start = 1'b1;
                if (!arr_stall) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                res_valid   = 1'b1;
                arr_row_sel = row_cnt;
                if (res_ready) begin
                    if (row_cnt == ROW_LAST) begin
                        done      = 1'b1;
                        row_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        row_nxt = row_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read port and result port views of the sequencer state.
    always_comb begin
        x_rd_en   = rd_en;
        w_rd_en   = rd_en;
        x_rd_addr = rd_en ? AW'(beat_cnt) : '0;
        w_rd_addr = rd_en ? AW'(beat_cnt) : '0;
        res_idx   = arr_row_sel;
        res_data  = res_valid ? arr_y_out : '0;
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: operand buffers, a black-box array result
// table, and a throughput model of tile timing.
module tb_systolic_array_ctrl;
    import systolic_array_pkg::*;

    localparam int N     = 4;
    localparam int AW    = $clog2(2*N);
    localparam int RW    = $clog2(N);
    localparam int SCHED = 512;

    typedef word_t [N-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic          busy, done, x_rd_en, w_rd_en, arr_start, res_valid;
    logic [AW-1:0] x_rd_addr, w_rd_addr;
    beat_t         x_rd_data = '0;
    beat_t         w_rd_data = '0;
    beat_t         arr_x_in, arr_w_in, arr_y_out, res_data;
    logic          arr_stall = 1'b0;
    logic          res_ready = 1'b1;
    logic [RW-1:0] arr_row_sel, res_idx;

    systolic_array_ctrl #(.N(N), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .busy        (busy),
        .done        (done),
        .x_rd_en     (x_rd_en),
        .w_rd_en     (w_rd_en),
        .x_rd_addr   (x_rd_addr),
        .w_rd_addr   (w_rd_addr),
        .x_rd_data   (x_rd_data),
        .w_rd_data   (w_rd_data),
        .arr_start   (arr_start),
        .arr_x_in    (arr_x_in),
        .arr_w_in    (arr_w_in),
        .arr_stall   (arr_stall),
        .arr_row_sel (arr_row_sel),
        .arr_y_out   (arr_y_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_idx     (res_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffers (synchronous read) and the array's result table.
    beat_t x_mem [2*N];
    beat_t w_mem [2*N];
    beat_t res_mem [N];

    always @(posedge clk) begin
        if (x_rd_en) x_rd_data <= x_mem[x_rd_addr];
        if (w_rd_en) w_rd_data <= w_mem[w_rd_addr];
    end

    assign arr_y_out = res_mem[arr_row_sel];

    // Per-cycle stimulus schedules, indexed by cycle offset from go.
    bit go_s     [SCHED];
    bit stall_s  [SCHED];
    bit ready_lo [SCHED];

    int total = 0;
    int bad   = 0;

    // Observation logs for the current tile.
    int    c0;
    bit    mon_en = 1'b0;
    int    rd_log[$];
    int    rdc_log[$];
    beat_t bx_q[$];
    beat_t bw_q[$];
    beat_t row_q[$];
    int    ridx_q[$];
    int    done_cnt, done_cyc, first_valid, busy_cnt, rdmis, hold_bad;
    logic  p_start, p_stall, p_valid, p_ready;
    beat_t p_x, p_w, p_res;
    logic [RW-1:0] p_idx;

    always @(negedge clk) begin
        int k;
        if (mon_en) begin
            k = cyc - c0;
            if (x_rd_en) begin
                rd_log.push_back(int'(x_rd_addr));
                rdc_log.push_back(k);
            end
            if (x_rd_en !== w_rd_en || x_rd_addr !== w_rd_addr) rdmis++;
            if (k >= 2 && arr_start && !arr_stall) begin
                bx_q.push_back(arr_x_in);
                bw_q.push_back(arr_w_in);
            end
            if (res_valid && first_valid < 0) first_valid = k;
            if (res_valid && res_ready) begin
                row_q.push_back(res_data);
                ridx_q.push_back(int'(res_idx));
            end
            if (done) begin
                done_cnt++;
                done_cyc = k;
            end
            if (busy) busy_cnt++;
            if (k >= 3 && p_start && p_stall && arr_start && (arr_x_in !== p_x || arr_w_in !== p_w))
                hold_bad++;
            if (k >= 1 && p_valid && !p_ready && (res_valid !== 1'b1 || res_data !== p_res || res_idx !== p_idx))
                hold_bad++;
        end
        p_start = arr_start;
        p_stall = arr_stall;
        p_x     = arr_x_in;
        p_w     = arr_w_in;
        p_valid = res_valid;
        p_ready = res_ready;
        p_res   = res_data;
        p_idx   = res_idx;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < SCHED; i++) begin
            go_s[i]     = 1'b0;
            stall_s[i]  = 1'b0;
            ready_lo[i] = 1'b0;
        end
    endtask

    // X ramp in 8.8 fixed point, W identity, results = X[0..N-1] * W.
    task automatic load_ramp_identity();
        for (int b = 0; b < 2*N; b++)
            for (int c = 0; c < N; c++) begin
                x_mem[b][c] = word_t'((b*N + c + 1) << 8);
                w_mem[b][c] = ((b % N) == c) ? word_t'(256) : word_t'(0);
            end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                int acc = 0;
                for (int k = 0; k < N; k++) acc += int'(x_mem[r][k]) * int'(w_mem[k][c]);
                res_mem[r][c] = word_t'(acc >>> 8);
            end
    endtask

    task automatic load_random();
        for (int b = 0; b < 2*N; b++)
            for (int c = 0; c < N; c++) begin
                x_mem[b][c] = word_t'($urandom);
                w_mem[b][c] = word_t'($urandom);
            end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) res_mem[r][c] = word_t'($urandom);
    endtask

    // From cycle 2 every unstalled cycle retires one array beat: 2N operands,
    // N-1 flush zeros and the WAIT exit. Rows then leave on ready cycles.
    task automatic model_timing(output int first_out, output int done_at);
        int need = 3*N;
        int t = 2;
        while (need > 0 && t < SCHED) begin
            if (!stall_s[t]) need--;
            t++;
        end
        first_out = t;
        need = N;
        done_at = -1;
        while (need > 0 && t < SCHED) begin
            if (!ready_lo[t]) begin
                need--;
                if (need == 0) done_at = t;
            end
            t++;
        end
    endtask

    task automatic run_tile(input int rst_at);
        int k;
        rd_log.delete(); rdc_log.delete(); bx_q.delete(); bw_q.delete();
        row_q.delete(); ridx_q.delete();
        done_cnt = 0; done_cyc = -1; first_valid = -1; busy_cnt = 0; rdmis = 0; hold_bad = 0;
        @(posedge clk); #1;
        c0        = cyc;
        mon_en    = 1'b1;
        go        = 1'b1;
        arr_stall = stall_s[0];
        res_ready = !ready_lo[0];
        forever begin
            @(posedge clk); #1;
            k         = cyc - c0;
            go        = go_s[k];
            arr_stall = stall_s[k];
            res_ready = !ready_lo[k];
            rst       = (k == rst_at);
            if (rst_at >= 0 && k == rst_at + 1) break;
            if (rst_at < 0 && done_cnt > 0 && k > done_cyc + 4) break;
            if (k >= 300) break;
        end
        mon_en    = 1'b0;
        go        = 1'b0;
        arr_stall = 1'b0;
        res_ready = 1'b1;
        rst       = 1'b0;
    endtask

    task automatic post_check(input string tag);
        int fo, dn;
        model_timing(fo, dn);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(dn));
        chk({tag, "_first_valid"}, 64'(first_valid), 64'(fo));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(dn));
        chk({tag, "_nreads"}, 64'(rd_log.size()), 64'(2*N));
        for (int i = 0; i < rd_log.size() && i < 2*N; i++)
            chk($sformatf("%s_raddr%0d", tag, i), 64'(rd_log[i]), 64'(i));
        chk({tag, "_xw_rd_match"}, 64'(rdmis), 64'(0));
        chk({tag, "_hold"}, 64'(hold_bad), 64'(0));
        chk({tag, "_nbeats"}, 64'(bx_q.size()), 64'(3*N));
        for (int i = 0; i < bx_q.size() && i < 3*N; i++) begin
            chk($sformatf("%s_xbeat%0d", tag, i), 64'(bx_q[i]), 64'((i < 2*N) ? x_mem[i] : '0));
            chk($sformatf("%s_wbeat%0d", tag, i), 64'(bw_q[i]), 64'((i < 2*N) ? w_mem[i] : '0));
        end
        chk({tag, "_nrows"}, 64'(row_q.size()), 64'(N));
        for (int i = 0; i < row_q.size() && i < N; i++) begin
            chk($sformatf("%s_ridx%0d", tag, i), 64'(ridx_q[i]), 64'(i));
            chk($sformatf("%s_row%0d", tag, i), 64'(row_q[i]), 64'(res_mem[i]));
        end
        chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, 64'({busy, done, x_rd_en, w_rd_en, arr_start, res_valid}), 64'(0));
        chk({tag, "_addr"}, 64'({x_rd_addr, w_rd_addr, arr_row_sel, res_idx}), 64'(0));
        chk({tag, "_arr_x"}, 64'(arr_x_in), 64'(0));
        chk({tag, "_arr_w"}, 64'(arr_w_in), 64'(0));
        chk({tag, "_res_data"}, 64'(res_data), 64'(0));
    endtask

    initial begin
        clear_sched();
        load_ramp_identity();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Clean tile: reads on cycles 1..8, done on cycle 17, rows = X*I.
        run_tile(-1);
        post_check("clean");
        chk("clean_done_abs", 64'(done_cyc), 64'(17));
        chk("clean_first_read", 64'(rdc_log.size() > 0 ? rdc_log[0] : -1), 64'(1));
        chk("clean_last_read", 64'(rdc_log.size() > 7 ? rdc_log[7] : -1), 64'(8));
        chk("clean_row1", 64'(row_q.size() > 1 ? row_q[1] : '0), 64'(x_mem[1]));

        // Stall for 3 cycles while beat 2 is on display.
        clear_sched();
        for (int i = 4; i < 7; i++) stall_s[i] = 1'b1;
        run_tile(-1);
        post_check("stall_b2");
        chk("stall_b2_done_abs", 64'(done_cyc), 64'(20));

        // Result sink not ready for 5 cycles on row 1.
        clear_sched();
        for (int i = 15; i < 20; i++) ready_lo[i] = 1'b1;
        run_tile(-1);
        post_check("ready_lo");
        chk("ready_lo_done_abs", 64'(done_cyc), 64'(22));

        // Reset in FLUSH, then a fresh clean tile.
        clear_sched();
        run_tile(11);
        @(negedge clk);
        chk_idle("rst_flush");
        run_tile(-1);
        post_check("after_rst");
        chk("after_rst_done_abs", 64'(done_cyc), 64'(17));

        // go while busy and coincident with done: one tile only.
        clear_sched();
        go_s[5]  = 1'b1;
        go_s[17] = 1'b1;
        run_tile(-1);
        post_check("go_ignored");

        // Stall held through WAIT after the last flush beat.
        clear_sched();
        for (int i = 13; i < 17; i++) stall_s[i] = 1'b1;
        run_tile(-1);
        post_check("wait_stall");
        chk("wait_stall_first_valid_abs", 64'(first_valid), 64'(18));

        // Random operands, stalls and back-pressure.
        for (int t = 0; t < 4; t++) begin
            clear_sched();
            load_random();
            for (int i = 1; i < 200; i++) begin
                stall_s[i]  = ($urandom_range(3) == 0);
                ready_lo[i] = ($urandom_range(2) == 0);
            end
            run_tile(-1);
            post_check($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
